uart_core: RTL and testbench

// Parametrised full-duplex UART: TX and RX share one clock, one baud generator config, one frame format.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_core.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART core: parity mode codes, TX/RX state
// encodings, a ceiling-log2 helper for sizing counters and a parity helper
// used by both the transmitter and the receiver.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Ceiling log2, never below 1 so it can size a counter directly.
    function automatic int log2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Narrower words are zero-extended by the caller; zeros do not change XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Fractional-accumulator rate generator. Adds a fixed increment every clock
// and emits a one-cycle tick on each carry out, giving an average tick rate
// of RATE with jitter of at most one clock.
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   enable  in   0 holds the accumulator at zero and suppresses ticks
//   tick    out  one-cycle pulse at RATE (combinational carry)
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLK_FREQ = 25000000,
    parameter int RATE     = 115200,
    parameter int ACC_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    // Increment is rounded to nearest; it may equal 2^ACC_W when RATE equals
    // CLK_FREQ, hence the extra bit (tick then fires every cycle).
    localparam longint unsigned INC_L =
        ((longint'(RATE) << ACC_W) + longint'(CLK_FREQ / 2)) / longint'(CLK_FREQ);
    localparam logic [ACC_W:0] INC = (ACC_W + 1)'(INC_L);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum  = {1'b0, acc} + INC;
    assign tick = enable & sum[ACC_W];

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            acc <= '0;
        end else begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core
// Full-duplex UART with configurable frame: 5..8 data bits, none/even/odd
// parity, 1 or 2 stop bits. TX and RX share one clock and frame format.
// RX reports sticky framing, parity and overrun errors.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   tx_start     in   send request, accepted when tx_busy==0
//   tx_data      in   word to send, latched on acceptance
//   tx_busy      out  frame in progress
//   txd          out  serial out, idle high
//   rxd          in   serial in, asynchronous
//   rx_valid     out  sticky, rx_data holds an unread word
//   rx_clear     in   clears rx_valid and all error flags
//   rx_data      out  last received word, LSB first on the line
//   frame_err    out  sticky, stop bit sampled low
//   parity_err   out  sticky, parity mismatch
//   overrun_err  out  sticky, frame completed while rx_valid was set
//
// TX states
//   state      | meaning
//   TX_IDLE    | line high, waiting for tx_start
//   TX_START   | driving start bit
//   TX_DATA    | driving data bits LSB first, tx_cnt counts down
//   TX_PARITY  | driving parity bit
//   TX_STOP    | driving stop bit(s), tx_cnt counts down
//
// RX states
//   state      | meaning
//   RX_IDLE    | waiting for filtered line low
//   RX_START   | timing to mid start bit, checks for false start
//   RX_DATA    | sampling data bits, rx_cnt counts down
//   RX_PARITY  | sampling parity bit
//   RX_STOP    | sampling stop bit, publishing word and flags
//   RX_BREAK   | stop bit was low, waiting for line to return high
// ---------------------------------------------------------------------------
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 rx_valid,
    input  logic                 rx_clear,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int ACC_W  = log2(CLK_FREQ / BAUD) + 8;
    localparam int BIT_W  = log2(DATA_BITS);
    localparam int OS_W   = log2(OVERSAMPLE);
    localparam bit PAR_EN = (PARITY != PAR_NONE);

    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [OS_W-1:0]  HALF_BIT  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_BIT  = OS_W'(OVERSAMPLE - 1);

    // ------------------------------------------------------------------
    // Baud generators
    // ------------------------------------------------------------------
    tx_state_t tx_state;
    logic      tx_tick;
    logic      rx_tick;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .RATE     (BAUD),
        .ACC_W    (ACC_W)
    ) u_tx_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (tx_state != TX_IDLE),
        .tick   (tx_tick)
    );

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .RATE     (BAUD * OVERSAMPLE),
        .ACC_W    (ACC_W)
    ) u_rx_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (1'b1),
        .tick   (rx_tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_shift;
    logic [BIT_W-1:0]     tx_cnt;
    logic                 tx_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_par   <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    // tx_busy is low in IDLE, so tx_start alone is acceptance
                    if (tx_start) begin
                        tx_state <= TX_START;
                        txd      <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_shift <= tx_data;
                        tx_par   <= parity_bit(8'(tx_data), PARITY);
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        txd      <= tx_shift[0];
                        tx_cnt   <= LAST_DATA;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_cnt == '0) begin
                            if (PAR_EN) begin
                                txd      <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                txd      <= 1'b1;
                                tx_cnt   <= LAST_STOP;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            txd      <= tx_shift[1];
                            tx_cnt   <= tx_cnt - BIT_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        txd      <= 1'b1;
                        tx_cnt   <= LAST_STOP;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (tx_cnt == '0) begin
                            tx_state <= TX_IDLE;
                            tx_busy  <= 1'b0;
                        end else begin
                            tx_cnt <= tx_cnt - BIT_W'(1);
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    txd      <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver input conditioning: 2-flop synchroniser, then a 2-bit
    // saturating counter on RX ticks with hysteresis at the rails.
    // ------------------------------------------------------------------
    logic       rxd_meta;
    logic       rxd_sync;
    logic [1:0] filt_cnt;
    logic       rxd_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            filt_cnt <= 2'b11;
            rxd_filt <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            if (rx_tick) begin
                if (rxd_sync && (filt_cnt != 2'b11)) begin
                    filt_cnt <= filt_cnt + 2'b01;
                    if (filt_cnt == 2'b10) rxd_filt <= 1'b1;
                end else if (!rxd_sync && (filt_cnt != 2'b00)) begin
                    filt_cnt <= filt_cnt - 2'b01;
                    if (filt_cnt == 2'b01) rxd_filt <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM. rx_os is a down-counter of RX ticks to the next
    // sample point; rx_cnt counts remaining data bits.
    // ------------------------------------------------------------------
    rx_state_t            rx_state;
    logic [OS_W-1:0]      rx_os;
    logic [BIT_W-1:0]     rx_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_os       <= '0;
            rx_cnt      <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Frame completion below is written later, so it wins over a
            // simultaneous clear.
            if (rx_clear) begin
                rx_valid    <= 1'b0;
                frame_err   <= 1'b0;
                parity_err  <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (rx_tick) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rxd_filt) begin
                            rx_os    <= HALF_BIT;
                            rx_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (rx_os != '0) begin
                            rx_os <= rx_os - OS_W'(1);
                        end else if (rxd_filt) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_os    <= FULL_BIT;
                            rx_cnt   <= LAST_DATA;
                            rx_state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (rx_os != '0) begin
                            rx_os <= rx_os - OS_W'(1);
                        end else begin
                            rx_os    <= FULL_BIT;
                            rx_shift <= {rxd_filt, rx_shift[DATA_BITS-1:1]};
                            if (rx_cnt == '0) begin
                                rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_cnt <= rx_cnt - BIT_W'(1);
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (rx_os != '0) begin
                            rx_os <= rx_os - OS_W'(1);
                        end else begin
                            rx_os    <= FULL_BIT;
                            rx_par   <= rxd_filt;
                            rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (rx_os != '0) begin
                            rx_os <= rx_os - OS_W'(1);
                        end else begin
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_clear) begin
                                overrun_err <= 1'b1;
                            end else begin
                                rx_data <= rx_shift;
                            end
                            if (!rxd_filt) frame_err <= 1'b1;
                            if (PAR_EN && (parity_bit(8'(rx_shift), PARITY) != rx_par)) begin
                                parity_err <= 1'b1;
                            end
                            rx_state <= rxd_filt ? RX_IDLE : RX_BREAK;
                        end
                    end
                    RX_BREAK: begin
                        if (rxd_filt) rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic drv;
    logic a_loop;

    // A: 8N1, loopback or driven line
    logic       a_start, a_busy, a_txd, a_rxd, a_valid, a_clear, a_fe, a_pe, a_oe;
    logic [7:0] a_data, a_rdata;
    assign a_rxd = a_loop ? a_txd : drv;

    // B: 7E2, loopback
    logic       b_start, b_busy, b_txd, b_valid, b_clear, b_fe, b_pe, b_oe;
    logic [6:0] b_data, b_rdata;

    // C: 8O1, driven line
    logic       c_start, c_busy, c_txd, c_valid, c_clear, c_fe, c_pe, c_oe;
    logic [7:0] c_data, c_rdata;

    logic [15:0] frame;

    uart_core #(.CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_start(a_start), .tx_data(a_data), .tx_busy(a_busy),
        .txd(a_txd), .rxd(a_rxd), .rx_valid(a_valid), .rx_clear(a_clear),
        .rx_data(a_rdata), .frame_err(a_fe), .parity_err(a_pe), .overrun_err(a_oe));

    uart_core #(.CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .tx_start(b_start), .tx_data(b_data), .tx_busy(b_busy),
        .txd(b_txd), .rxd(b_txd), .rx_valid(b_valid), .rx_clear(b_clear),
        .rx_data(b_rdata), .frame_err(b_fe), .parity_err(b_pe), .overrun_err(b_oe));

    uart_core #(.CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .tx_start(c_start), .tx_data(c_data), .tx_busy(c_busy),
        .txd(c_txd), .rxd(drv), .rx_valid(c_valid), .rx_clear(c_clear),
        .rx_data(c_rdata), .frame_err(c_fe), .parity_err(c_pe), .overrun_err(c_oe));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drv = bits[i];
            cyc(16);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; drv = 1'b1; a_loop = 1'b1;
        a_start = 0; a_data = '0; a_clear = 0;
        b_start = 0; b_data = '0; b_clear = 0;
        c_start = 0; c_data = '0; c_clear = 0;
        cyc(3);

        // Reset state
        check("rst_a_txd", a_txd, 1);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_flags", {a_valid, a_fe, a_pe, a_oe}, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_state", {b_txd, b_busy, b_valid, b_fe, b_pe, b_oe}, 6'b100000);
        check("rst_c_state", {c_txd, c_busy, c_valid, c_fe, c_pe, c_oe}, 6'b100000);
        rst = 1'b0;
        cyc(2);

        // 8N1 0xA5 on the line, loopback receive
        a_data = 8'hA5; a_start = 1; cyc(1); a_start = 0;
        check("a5_busy_after_accept", a_busy, 1);
        check("a5_txd_low_after_accept", a_txd, 0);
        a_data = 8'hFF; a_start = 1; cyc(1); a_start = 0;   // ignored while busy
        cyc(7);
        frame = {6'b0, 1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_bit%0d", k), a_txd, frame[k]);
            if (k < 9) cyc(16);
        end
        cyc(7);
        check("a5_busy_last_stop_cycle", a_busy, 1);
        cyc(1);
        check("a5_busy_fall", a_busy, 0);
        check("a5_txd_idle", a_txd, 1);
        for (int i = 0; i < 50 && a_valid !== 1'b1; i++) cyc(1);
        check("a5_rx_valid", a_valid, 1);
        check("a5_rx_data", a_rdata, 8'hA5);
        check("a5_rx_errs", {a_fe, a_pe, a_oe}, 0);
        a_clear = 1; cyc(1); a_clear = 0;
        check("a5_clear_valid", a_valid, 0);

        // 7E2 0x35: parity 0, two stop periods
        b_data = 7'h35; b_start = 1; cyc(1); b_start = 0;
        cyc(8);
        frame = {5'b0, 2'b11, 1'b0, 7'h35, 1'b0};
        for (int k = 0; k < 11; k++) begin
            check($sformatf("b35_bit%0d", k), b_txd, frame[k]);
            if (k < 10) cyc(16);
        end
        cyc(7);
        check("b35_busy_second_stop", b_busy, 1);
        cyc(1);
        check("b35_busy_fall", b_busy, 0);
        for (int i = 0; i < 50 && b_valid !== 1'b1; i++) cyc(1);
        check("b35_rx_valid", b_valid, 1);
        check("b35_rx_data", b_rdata, 7'h35);
        check("b35_rx_errs", {b_fe, b_pe, b_oe}, 0);

        // 8O1 frame 0x00 with wrong parity bit 0
        drive_bits(16'b0000_0100_0000_0000, 11);
        cyc(20);
        check("c00_rx_valid", c_valid, 1);
        check("c00_parity_err", c_pe, 1);
        check("c00_frame_err", c_fe, 0);
        check("c00_rx_data", c_rdata, 8'h00);
        c_clear = 1; cyc(1); c_clear = 0;
        check("c00_clear_valid", c_valid, 0);
        check("c00_clear_parity", c_pe, 0);

        // 8N1 0x55 with low stop bit, line held low afterwards (break)
        a_loop = 1'b0;
        drive_bits({6'b0, 1'b0, 8'h55, 1'b0}, 10);
        cyc(100);
        drv = 1'b1;
        cyc(200);
        check("a55_rx_valid", a_valid, 1);
        check("a55_frame_err", a_fe, 1);
        check("a55_rx_data", a_rdata, 8'h55);
        check("a55_no_retrigger", {a_oe, a_pe}, 0);
        a_clear = 1; cyc(1); a_clear = 0;
        check("a55_clear_fe", a_fe, 0);

        // 1-clk glitch on idle line
        drv = 1'b0; cyc(1); drv = 1'b1;
        cyc(200);
        check("glitch_no_valid", a_valid, 0);
        check("glitch_no_fe", a_fe, 0);
        a_loop = 1'b1;
        cyc(2);

        // Overrun: 0x11 then 0x22 without clearing
        a_data = 8'h11; a_start = 1; cyc(1); a_start = 0;
        for (int i = 0; i < 300 && a_busy; i++) cyc(1);
        check("ovr_first_done", a_busy, 0);
        a_data = 8'h22; a_start = 1; cyc(1); a_start = 0;
        for (int i = 0; i < 300 && a_busy; i++) cyc(1);
        check("ovr_second_done", a_busy, 0);
        cyc(5);
        check("ovr_overrun_err", a_oe, 1);
        check("ovr_rx_data_kept", a_rdata, 8'h11);
        check("ovr_rx_valid", a_valid, 1);
        a_clear = 1; cyc(1); a_clear = 0;
        check("ovr_clear", {a_valid, a_oe}, 0);
        cyc(2);

        // Reset at clk 40 of a TX frame, then immediate restart
        a_data = 8'h0F; a_start = 1; cyc(1); a_start = 0;
        cyc(39);
        rst = 1'b1; cyc(1);
        check("rst_mid_txd", a_txd, 1);
        check("rst_mid_busy", a_busy, 0);
        rst = 1'b0;
        a_data = 8'h3C; a_start = 1; cyc(1); a_start = 0;
        check("restart_busy", a_busy, 1);
        check("restart_txd", a_txd, 0);
        for (int i = 0; i < 300 && a_valid !== 1'b1; i++) cyc(1);
        check("restart_rx_valid", a_valid, 1);
        check("restart_rx_data", a_rdata, 8'h3C);
        check("restart_rx_errs", {a_fe, a_pe, a_oe}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
